mem_access_unit: RTL and testbench

- CPU-side initiator for the word-wide data memory: accepts load/store requests from the pipeline's MEM stage, drives the memory's address/data/MemWrite/MemRead interface and returns load results.
- Handles byte/half/word sizes on a 32-bit word memory: sub-word loads use lane extraction plus sign/zero extension; sub-word stores use read-modify-write.
- Sits between the pipeline (valid/ready request, single-cycle response pulse) and data memory (word-indexed, combinational read, level-sensitive write).

---
 rtl/cpu_mem_pkg.sv | 18 +
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mau_lane_align.sv | 30 +++
 rtl/mem_access_unit.sv | 105 ++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared size encodings, FSM state enum and lane-select helpers for mem_access_unit.
// Contents: SZ_BYTE/SZ_HALF/SZ_WORD access sizes (11 is treated as word), lane masks,
// state_t FSM encoding, is_subword() and natural_off() helpers.
package cpu_mem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] HALF_LANE_MASK = 2'b10;
    localparam logic [1:0] WORD_LANE_OFF = 2'b00;
    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_WR, RESP} state_t;
    function automatic logic is_subword(input logic [1:0] size);
        return size == SZ_BYTE || size == SZ_HALF;
    endfunction
    // Byte offset forced to the natural alignment of the access size.
    function automatic logic [1:0] natural_off(input logic [1:0] size, input logic [1:0] off);
        return size == SZ_BYTE ? off : size == SZ_HALF ? off & HALF_LANE_MASK : WORD_LANE_OFF;
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: pipeline request/response and data-memory bus for mem_access_unit.
// Pipeline side: req_valid/req_ready/req_write/req_size/req_signed/req_addr/req_wdata,
// rsp_valid/rsp_rdata/rsp_err. Memory side: memAddress/memWriteData/memWrite/memRead/memReadData.
// slave = the unit, master = pipeline plus memory model.
interface mem_access_unit_if #(parameter int ADDR_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] memAddress;
    logic [31:0]       memWriteData;
    logic              memWrite;
    logic              memRead;
    logic [31:0]       memReadData;
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, memReadData,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, memAddress, memWriteData, memWrite, memRead
    );
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, memReadData,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, memAddress, memWriteData, memWrite, memRead
    );
endinterface

// File: rtl/mau_lane_align.sv
// mau_lane_align: combinational little-endian lane extract/extend for loads and lane merge for stores.
// Ports: i_size access size, i_off byte offset, i_signed sign-extend loads, i_rdata memory word,
// i_wdata right-aligned store data, o_load extended load result, o_merge merged write word.
module mau_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
    assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];
    assign o_load = i_size == SZ_BYTE ? {{24{i_signed & w_byte[7]}}, w_byte} :
                    i_size == SZ_HALF ? {{16{i_signed & w_half[15]}}, w_half} : i_rdata;
    always_comb begin
        o_merge = i_rdata;
        if (i_size == SZ_BYTE)
            o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
        else if (i_size == SZ_HALF)
            o_merge[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
        else
            o_merge = i_wdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the MEM stage and a word-wide data memory.
// Ports: clk, rst_n (synchronous active-low), bus (mem_access_unit_if.slave) carrying the
// pipeline request/response handshake and the memory address/data/strobe interface.
// Parameters: READ_LAT (1..15) cycles memRead is held, ADDR_W address width.
// Option: MAU_MISALIGN_TRAP_EN traps misaligned half/word accesses with rsp_err instead of
// forcing natural alignment.
module mem_access_unit
    import cpu_mem_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 32
) (
    input logic               clk,
    input logic               rst_n,
    mem_access_unit_if.slave  bus
);
    state_t            r_state, w_next;
    logic [3:0]        r_cnt;
    logic [1:0]        r_off, r_size;
    logic              r_signed;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata, r_rsp_rdata;
    logic              r_rsp_err;
    logic              w_accept, w_mis, w_rd_done;
    logic [1:0]        w_off;
    logic [31:0]       w_load, w_merge;
`ifdef MAU_MISALIGN_TRAP_EN
    assign w_off = bus.req_addr[1:0];
    assign w_mis = w_off != natural_off(bus.req_size, bus.req_addr[1:0]);
`else
    assign w_off = natural_off(bus.req_size, bus.req_addr[1:0]);
    assign w_mis = 1'b0;
`endif
    assign w_accept  = bus.req_valid && r_state == IDLE;
    assign w_rd_done = r_cnt == 4'(READ_LAT - 1);
    assign bus.req_ready    = r_state == IDLE;
    assign bus.rsp_valid    = r_state == RESP;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.memRead      = r_state == RD || r_state == RMW_RD;
    assign bus.memWrite     = r_state == WR || r_state == RMW_WR;
    assign bus.memAddress   = r_mem_addr;
    assign bus.memWriteData = r_mem_wdata;
    mau_lane_align u_align (
        .i_size   (r_size),
        .i_off    (r_off),
        .i_signed (r_signed),
        .i_rdata  (bus.memReadData),
        .i_wdata  (r_mem_wdata),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );
    always_ff @(posedge clk) begin
        r_state <= !rst_n ? IDLE : w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid)
                         w_next = w_mis ? RESP : !bus.req_write ? RD : is_subword(bus.req_size) ? RMW_RD : WR;
            RD:      if (w_rd_done) w_next = RESP;
            RMW_RD:  if (w_rd_done) w_next = RMW_WR;
            WR:      w_next = RESP;
            RMW_WR:  w_next = RESP;
            default: w_next = IDLE;
        endcase
    end
    // Word stores carry req_wdata straight through r_mem_wdata; sub-word stores replace it
    // with the merged word on the last read cycle, which is why wdata needs no own register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_off       <= '0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_cnt <= (r_state == RD || r_state == RMW_RD) && !w_rd_done ? r_cnt + 4'd1 : 4'd0;
            if (w_accept) begin
                r_off       <= w_off;
                r_size      <= bus.req_size;
                r_signed    <= bus.req_signed;
                r_mem_addr  <= bus.req_addr >> 2;
                r_mem_wdata <= bus.req_wdata;
                if (w_mis) begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end
            end
            if (r_state == RD && w_rd_done) begin
                r_rsp_rdata <= w_load;
                r_rsp_err   <= 1'b0;
            end
            if (r_state == RMW_RD && w_rd_done)
                r_mem_wdata <= w_merge;
            if (r_state == WR || r_state == RMW_WR) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a 16-word memory
// model (word i = 5*i, word 4 = 0x000080FF) and READ_LAT = 1. Honours MAU_MISALIGN_TRAP_EN.
module tb_mem_access_unit;
    import cpu_mem_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        loaded = 1'b0;
    logic [31:0] mem [0:15];
    int          tests = 0;
    int          fails = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          rsp_cnt = 0;
    logic [31:0] wr_addr = '0;
    mem_access_unit_if #(.ADDR_W(32)) bus ();
    mem_access_unit #(.READ_LAT(1), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    assign bus.memReadData = mem[bus.memAddress[3:0]];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(5 * i);
            mem[4] <= 32'h0000_80FF;
            loaded <= 1'b1;
        end else if (bus.memWrite)
            mem[bus.memAddress[3:0]] <= bus.memWriteData;
    end
    always @(negedge clk) begin
        if (bus.memRead) rd_cycles = rd_cycles + 1;
        if (bus.memWrite) begin
            wr_cycles = wr_cycles + 1;
            wr_addr = bus.memAddress;
        end
        if (bus.rsp_valid) rsp_cnt = rsp_cnt + 1;
    end

    // Issues one request from just after an edge; lat counts edges from accept to the edge
    // that samples rsp_valid (timeout yields a latency no check accepts).
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int n;
        rd_cycles = 0;
        wr_cycles = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size = sz;
        bus.req_signed = sg;
        bus.req_addr = a;
        bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        lat = n + 1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", bus.req_ready); end
        tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid); end
        tests++; if (bus.rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata got %h exp 0", bus.rsp_rdata); end
        tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp_err got %b exp 0", bus.rsp_err); end
        tests++; if (bus.memWrite !== 1'b0) begin fails++; $display("FAIL reset_memWrite got %b exp 0", bus.memWrite); end
        tests++; if (bus.memRead !== 1'b0) begin fails++; $display("FAIL reset_memRead got %b exp 0", bus.memRead); end
        tests++; if (bus.memAddress !== 32'h0) begin fails++; $display("FAIL reset_memAddress got %h exp 0", bus.memAddress); end
        tests++; if (bus.memWriteData !== 32'h0) begin fails++; $display("FAIL reset_memWriteData got %h exp 0", bus.memWriteData); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load;
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b0, SZ_WORD, 1'b0, 32'h0C, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h0000_000F) begin fails++; $display("FAIL word_load_data got %h exp 0000000f", rd); end
        tests++; if (lat != 2) begin fails++; $display("FAIL word_load_lat got %0d exp 2", lat); end
        tests++; if (rd_cycles != 1) begin fails++; $display("FAIL word_load_memRead_cycles got %0d exp 1", rd_cycles); end
        tests++; if (wr_cycles != 0) begin fails++; $display("FAIL word_load_memWrite_cycles got %0d exp 0", wr_cycles); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL word_load_err got %b exp 0", er); end
        tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin fails++; $display("FAIL word_load_pulse got valid %b ready %b exp 0 1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_subword_load;
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h10, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL sbyte_load got %h exp ffffffff", rd); end
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h0000_0080) begin fails++; $display("FAIL ubyte_load got %h exp 00000080", rd); end
        do_req(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'hFFFF_80FF) begin fails++; $display("FAIL shalf_load got %h exp ffff80ff", rd); end
        do_req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h0000_0000) begin fails++; $display("FAIL uhalf_hi_load got %h exp 00000000", rd); end
    endtask

    task automatic test_stores;
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b1, SZ_HALF, 1'b0, 32'h16, 32'h1234_BEEF, rd, er, lat);
        tests++; if (mem[5] !== 32'hBEEF_0019) begin fails++; $display("FAIL half_store_word got %h exp beef0019", mem[5]); end
        tests++; if (lat != 3) begin fails++; $display("FAIL half_store_lat got %0d exp 3", lat); end
        tests++; if (wr_cycles != 1) begin fails++; $display("FAIL half_store_memWrite_cycles got %0d exp 1", wr_cycles); end
        tests++; if (wr_addr !== 32'd5) begin fails++; $display("FAIL half_store_memAddress got %h exp 5", wr_addr); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL half_store_rdata got %h exp 0", rd); end
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h13, 32'h0000_00AB, rd, er, lat);
        tests++; if (mem[4] !== 32'hAB00_80FF) begin fails++; $display("FAIL byte3_store_word got %h exp ab0080ff", mem[4]); end
        do_req(1'b1, SZ_WORD, 1'b0, 32'h1C, 32'hDEAD_BEEF, rd, er, lat);
        tests++; if (mem[7] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL word_store_word got %h exp deadbeef", mem[7]); end
        tests++; if (lat != 2) begin fails++; $display("FAIL word_store_lat got %0d exp 2", lat); end
        tests++; if (rd_cycles != 0) begin fails++; $display("FAIL word_store_memRead_cycles got %0d exp 0", rd_cycles); end
    endtask

    task automatic test_misalign;
        logic [31:0] rd;
        logic er;
        int lat;
        do_req(1'b0, SZ_WORD, 1'b0, 32'h0A, 32'h0, rd, er, lat);
`ifdef MAU_MISALIGN_TRAP_EN
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL misalign_err got %b exp 1", er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL misalign_rdata got %h exp 0", rd); end
        tests++; if (lat != 1) begin fails++; $display("FAIL misalign_lat got %0d exp 1", lat); end
        tests++; if (rd_cycles != 0 || wr_cycles != 0) begin fails++; $display("FAIL misalign_mem_access got rd %0d wr %0d exp 0 0", rd_cycles, wr_cycles); end
`else
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL align_err got %b exp 0", er); end
        tests++; if (rd !== 32'h0000_000A) begin fails++; $display("FAIL align_rdata got %h exp 0000000a", rd); end
        tests++; if (lat != 2) begin fails++; $display("FAIL align_lat got %0d exp 2", lat); end
`endif
    endtask

    task automatic test_reset_midflight;
        wr_cycles = 0;
        rsp_cnt = 0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size = SZ_BYTE;
        bus.req_signed = 1'b0;
        bus.req_addr = 32'h14;
        bus.req_wdata = 32'h0000_0077;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        tests++; if (bus.memRead !== 1'b1) begin fails++; $display("FAIL midreset_in_rmw_rd got %b exp 1", bus.memRead); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready got %b exp 1", bus.req_ready); end
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        tests++; if (wr_cycles != 0) begin fails++; $display("FAIL midreset_memWrite_cycles got %0d exp 0", wr_cycles); end
        tests++; if (rsp_cnt != 0) begin fails++; $display("FAIL midreset_rsp_count got %0d exp 0", rsp_cnt); end
        tests++; if (mem[5] !== 32'hBEEF_0019) begin fails++; $display("FAIL midreset_word5 got %h exp beef0019", mem[5]); end
    endtask

    task automatic test_back_to_back;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr = 32'h00;
        @(posedge clk); #1;
        tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_rd1 got %b exp 0", bus.req_ready); end
        bus.req_addr = 32'h04;
        @(posedge clk); #1;
        tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin fails++; $display("FAIL b2b_rsp1 got valid %b data %h exp 1 0", bus.rsp_valid, bus.rsp_rdata); end
        tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_resp1 got %b exp 0", bus.req_ready); end
        @(posedge clk); #1;
        tests++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_idle got ready %b valid %b exp 1 0", bus.req_ready, bus.rsp_valid); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_rd2 got %b exp 0", bus.req_ready); end
        @(posedge clk); #1;
        tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h5) begin fails++; $display("FAIL b2b_rsp2 got valid %b data %h exp 1 5", bus.rsp_valid, bus.rsp_rdata); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_word_load;
        test_subword_load;
        test_stores;
        test_misalign;
        test_reset_midflight;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
